// File: rtl/uart_string_parser.sv
// Purpose : extract the payload of "&&" payload "&&" frames from a UART byte stream.
// Latency : rx_done/rx_err pulse one cycle after the strobe of the terminating/offending byte.
// Backpr. : none; rx_vld is a strobe. Bytes arriving in the DONE/ERR cycle are dropped.
//
// Ports:
//   sys_clk    - sole clock, rising edge
//   sys_rst_n  - asynchronous active-low reset
//   rx_data    - received byte, qualified by rx_vld
//   rx_vld     - one-cycle strobe from the UART byte receiver
//   rx_string  - last completed payload, byte k at bits [8k+7:8k], zero above rx_length
//   rx_length  - payload byte count of the last completed frame
//   rx_busy    - high while a frame is being received
//   rx_done    - one-cycle pulse: rx_string/rx_length hold a new frame
//   rx_err     - one-cycle pulse: frame aborted (bad terminator, overflow or gap timeout)
module uart_string_parser #(
  parameter int MAX_LEN     = 128,
  parameter int TIMEOUT_CLK = 100_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_vld,
  output logic [MAX_LEN*8-1:0]   rx_string,
  output logic [7:0]             rx_length,
  output logic                   rx_busy,
  output logic                   rx_done,
  output logic                   rx_err
);

  localparam logic [7:0] AMP   = 8'h26;
  localparam int         GAP_W = $clog2(TIMEOUT_CLK + 1);

  typedef enum logic [2:0] {
    IDLE,
    SOF1,
    PAYLOAD,
    EOF1,
    DONE,
    ERR
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [MAX_LEN*8-1:0] work_buf;
  logic [7:0]           byte_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  logic in_frame;
  logic is_amp;
  logic buf_full;
  logic gap_expire;
  logic frame_start;
  logic store_en;

  assign in_frame = (state == SOF1) || (state == PAYLOAD) || (state == EOF1);
  assign is_amp   = (rx_data == AMP);
  assign buf_full = (byte_cnt == 8'(MAX_LEN));

  // The gap counter would reach TIMEOUT_CLK on this edge; checking the
  // incremented value lets rx_err follow the last idle cycle directly.
  assign gap_expire = in_frame && !rx_vld && (gap_cnt == GAP_W'(TIMEOUT_CLK - 1));

  assign frame_start = (state == SOF1) && rx_vld && is_amp && !gap_expire;
  assign store_en    = (state == PAYLOAD) && rx_vld && !is_amp && !buf_full;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_vld && is_amp) state_nxt = SOF1;
      end
      SOF1: begin
        if (gap_expire)  state_nxt = ERR;
        else if (rx_vld) state_nxt = is_amp ? PAYLOAD : IDLE;
      end
      PAYLOAD: begin
        if (gap_expire) begin
          state_nxt = ERR;
        end else if (rx_vld) begin
          if (is_amp)        state_nxt = EOF1;
          else if (buf_full) state_nxt = ERR;
        end
      end
      EOF1: begin
        if (gap_expire)  state_nxt = ERR;
        else if (rx_vld) state_nxt = is_amp ? DONE : ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Inter-byte gap counter: only runs inside a frame, restarts on every byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              gap_cnt <= '0;
    else if (!in_frame || rx_vld) gap_cnt <= '0;
    else                          gap_cnt <= gap_cnt + 1'b1;
  end

  // Working buffer: cleared at start of frame so unwritten bytes read as zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      work_buf <= '0;
      byte_cnt <= '0;
    end else if (frame_start) begin
      work_buf <= '0;
      byte_cnt <= '0;
    end else if (store_en) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (byte_cnt == 8'(k)) work_buf[k*8 +: 8] <= rx_data;
      end
      byte_cnt <= byte_cnt + 8'd1;
    end
  end

  // Published frame is captured on the edge entering DONE so it is valid
  // in the same cycle rx_done is high, and held until the next good frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_string <= '0;
      rx_length <= '0;
    end else if (state_nxt == DONE) begin
      rx_string <= work_buf;
      rx_length <= byte_cnt;
    end
  end

  assign rx_busy = in_frame;
  assign rx_done = (state == DONE);
  assign rx_err  = (state == ERR);

endmodule

// File: tb/tb_uart_string_parser.sv
module tb_uart_string_parser;

  localparam int ML = 4;
  localparam int TO = 50;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [7:0]      rx_data;
  logic            rx_vld;
  logic [ML*8-1:0] rx_string;
  logic [7:0]      rx_length;
  logic            rx_busy;
  logic            rx_done;
  logic            rx_err;

  uart_string_parser #(.MAX_LEN(ML), .TIMEOUT_CLK(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .rx_string (rx_string),
    .rx_length (rx_length),
    .rx_busy   (rx_busy),
    .rx_done   (rx_done),
    .rx_err    (rx_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: tracks the frame in terms of "seen one &", "inside
  // payload", "seen closing &" and the collected payload bytes.
  bit          m_pre;
  bit          m_sync;
  bit          m_close;
  logic [7:0]  m_pl[$];
  logic [31:0] exp_str;
  logic [7:0]  exp_len;

  function automatic void model_reset();
    m_pre   = 0;
    m_sync  = 0;
    m_close = 0;
    m_pl.delete();
    exp_str = '0;
    exp_len = '0;
  endfunction

  function automatic void model_abort();
    m_pre   = 0;
    m_sync  = 0;
    m_close = 0;
  endfunction

  function automatic bit model_busy();
    return m_pre || m_sync;
  endfunction

  function automatic void model_byte(input logic [7:0] b, output bit d, output bit e);
    d = 0;
    e = 0;
    if (!m_sync) begin
      if (b == 8'h26) begin
        if (m_pre) begin
          m_sync = 1;
          m_pre  = 0;
          m_pl.delete();
        end else begin
          m_pre = 1;
        end
      end else begin
        m_pre = 0;
      end
    end else if (m_close) begin
      if (b == 8'h26) begin
        d       = 1;
        exp_len = 8'(m_pl.size());
        exp_str = '0;
        for (int i = 0; i < m_pl.size(); i++) exp_str[i*8 +: 8] = m_pl[i];
      end else begin
        e = 1;
      end
      model_abort();
    end else if (b == 8'h26) begin
      m_close = 1;
    end else if (m_pl.size() == ML) begin
      e = 1;
      model_abort();
    end else begin
      m_pl.push_back(b);
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input bit d, input bit e, input bit busy);
    chk({tag, "_done"}, 64'(rx_done), 64'(d));
    chk({tag, "_err"},  64'(rx_err),  64'(e));
    chk({tag, "_busy"}, 64'(rx_busy), 64'(busy));
    chk({tag, "_len"},  64'(rx_length), 64'(exp_len));
    chk({tag, "_str"},  64'(rx_string), 64'(exp_str));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit d;
    bit e;
    model_byte(b, d, e);
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
    rx_data = $urandom_range(0, 255);
    chk_outputs("byte", d, e, (d || e) ? 1'b0 : model_busy());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_outputs("idle", 1'b0, 1'b0, model_busy());
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      idle(1);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 3))
      0:       return 8'h26;
      1:       return 8'h41 + 8'($urandom_range(0, 25));
      2:       return 8'h26;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    sys_rst_n = 1'b0;
    rx_vld    = 1'b0;
    rx_data   = 8'h00;
    model_reset();
    tick();
    tick();
    chk_outputs("reset", 1'b0, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    idle(2);

    // Basic frame
    send_str("&&ABC&&");
    chk("abc_len", 64'(rx_length), 64'd3);
    chk("abc_str", 64'(rx_string), 64'h0043_4241);

    // Empty frame then leading noise
    send_str("&&&&");
    chk("empty_len", 64'(rx_length), 64'd0);
    chk("empty_str", 64'(rx_string), 64'd0);
    send_str("xy&&Q&&");
    chk("q_len", 64'(rx_length), 64'd1);
    chk("q_str", 64'(rx_string), 64'h51);

    // Overflow with MAX_LEN = 4: previous frame must survive
    send_str("&&ABCDE");
    chk("ovf_keep_len", 64'(rx_length), 64'd1);
    chk("ovf_keep_str", 64'(rx_string), 64'h51);

    // Bad terminator, then recovery
    send_str("&&AB&C");
    send_str("&&Z&&");
    chk("z_len", 64'(rx_length), 64'd1);
    chk("z_str", 64'(rx_string), 64'h5A);

    // 49-cycle gap is tolerated
    send_byte(8'h26); idle(1);
    send_byte(8'h26); idle(1);
    send_byte(8'h41); idle(49);
    send_byte(8'h26); idle(1);
    send_byte(8'h26); idle(1);
    chk("gap49_len", 64'(rx_length), 64'd1);
    chk("gap49_str", 64'(rx_string), 64'h41);

    // 50-cycle gap times out
    send_byte(8'h26); idle(1);
    send_byte(8'h26); idle(1);
    send_byte(8'h41); idle(49);
    tick();
    model_abort();
    chk_outputs("timeout", 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset in the middle of a frame
    send_str("&&AB");
    #3;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("rst_mid", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    idle(3);
    send_str("&&C&&");
    chk("rst_c_len", 64'(rx_length), 64'd1);
    chk("rst_c_str", 64'(rx_string), 64'h43);

    // Randomized traffic: well-formed frames with noise, and raw byte soup
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        int plen;
        for (int n = $urandom_range(0, 2); n > 0; n--) begin
          send_byte(8'h41 + 8'($urandom_range(0, 25)));
          idle($urandom_range(1, 3));
        end
        plen = $urandom_range(0, ML + 1);
        send_byte(8'h26); idle($urandom_range(1, 3));
        send_byte(8'h26); idle($urandom_range(1, 3));
        for (int k = 0; k < plen; k++) begin
          logic [7:0] pb;
          pb = 8'($urandom_range(0, 255));
          if (pb == 8'h26) pb = 8'h27;
          send_byte(pb);
          idle($urandom_range(1, 3));
        end
        send_byte(8'h26); idle($urandom_range(1, 3));
        send_byte(8'h26); idle($urandom_range(1, 3));
      end else begin
        for (int k = 0; k < 6; k++) begin
          send_byte(rand_byte());
          idle($urandom_range(1, 3));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
